// File: rtl/synapse_array_pkg.sv
// Shared types and helpers for the synapse bank: accumulator sizing, FSM encoding, weight saturation.
// Combinational helpers only; no latency, no flow control.
package snn_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   function automatic int acc_dw(input int n_pre, input int w_dw);
      return w_dw + $clog2(n_pre);
   endfunction

   // Signed add clamped to the w_dw-bit two's complement range.
   function automatic int sat_add(input int w, input int delta, input int w_dw);
      longint s;
      longint hi;
      longint lo;
      s  = longint'(w) + longint'(delta);
      hi = (longint'(1) <<< (w_dw - 1)) - 1;
      lo = -(longint'(1) <<< (w_dw - 1));
      if (s > hi) begin
         return int'(hi);
      end
      if (s < lo) begin
         return int'(lo);
      end
      return int'(s);
   endfunction

endpackage

// File: rtl/synapse_array_if.sv
// Spike, weight-write and current bundle between the spike fabric and one synapse bank.
// Wires only; spike_valid/spike_ready carry the handshake, weight writes are unconditional.
interface synapse_array_if
   import snn_pkg::*;
#(
   parameter int N_PRE = 8,
   parameter int W_DW  = 16
);
   localparam int ACC_DW = acc_dw(N_PRE, W_DW);
   localparam int IDX_W  = $clog2(N_PRE);

   logic                     spike_valid;
   logic                     spike_ready;
   logic [N_PRE-1:0]         spike_vec;
   logic                     w_we;
   logic [IDX_W-1:0]         w_addr;
   logic signed [W_DW-1:0]   w_data;
   logic signed [ACC_DW-1:0] current;
   logic                     current_valid;
   logic                     post_spike;

   modport master (
      output spike_valid, spike_vec, w_we, w_addr, w_data, post_spike,
      input  spike_ready, current, current_valid
   );

   modport slave (
      input  spike_valid, spike_vec, w_we, w_addr, w_data, post_spike,
      output spike_ready, current, current_valid
   );
endinterface

// File: rtl/synapse_array_trace.sv
// syn_trace: per-input eligibility trace, reloaded to full scale on a spike, else decays by one per accepted vector.
// One-cycle update; follows the bank's accept strobe, no backpressure of its own.
module syn_trace #(
   parameter int T_DW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            accept,
   input  logic            bit_in,
   output logic [T_DW-1:0] trace
);
   always_ff @(posedge clk) begin
      if (rst) begin
         trace <= '0;
      end else if (accept) begin
         if (bit_in) begin
            trace <= '1;
         end else if (trace != '0) begin
            trace <= trace - 1'b1;
         end
      end
   end
endmodule

// File: rtl/synapse_array.sv
// synapse_array: sums weights of spiking inputs into one signed current; STDP learning under SYN_STDP_EN.
// Latency: current/current_valid register N_PRE+1 cycles after the accept edge (visible in cycle accept+N_PRE+2).
// Backpressure: spike_ready is high only in IDLE; weight writes are accepted in every state.
module synapse_array
   import snn_pkg::*;
#(
   parameter int N_PRE = 8,
   parameter int W_DW  = 16
`ifdef SYN_STDP_EN
   ,
   parameter int T_DW  = 4,
   parameter int LR    = 1
`endif
) (
   input logic            clk,
   input logic            rst,
   synapse_array_if.slave bus
);
   localparam int ACC_DW = acc_dw(N_PRE, W_DW);
   localparam int IDX_W  = $clog2(N_PRE);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_ACCUM = ACCUM;
   localparam logic [1:0] S_DONE  = DONE;

   logic [1:0]               state;
   logic [IDX_W-1:0]         idx;
   logic [N_PRE-1:0]         vec_q;
   logic signed [ACC_DW-1:0] acc;
   logic signed [W_DW-1:0]   w_mem [N_PRE];
   logic signed [W_DW-1:0]   w_cur;
   logic signed [ACC_DW-1:0] w_ext;
   logic                     accept;

   assign bus.spike_ready = (state == S_IDLE);
   assign accept          = bus.spike_valid && (state == S_IDLE);
   assign w_cur           = w_mem[idx];
   assign w_ext           = {{(ACC_DW - W_DW){w_cur[W_DW-1]}}, w_cur};

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= S_IDLE;
         idx               <= '0;
         vec_q             <= '0;
         acc               <= '0;
         bus.current       <= '0;
         bus.current_valid <= 1'b0;
      end else begin
         bus.current_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  vec_q <= bus.spike_vec;
                  acc   <= '0;
                  idx   <= '0;
                  state <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               // Weight read and any same-cycle write race resolve to the old weight.
               if (vec_q[idx]) begin
                  acc <= acc + w_ext;
               end
               if (idx == IDX_W'(N_PRE - 1)) begin
                  state <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_DONE: begin
               bus.current       <= acc;
               bus.current_valid <= 1'b1;
               state             <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef SYN_STDP_EN
   logic [T_DW-1:0]  trace_q [N_PRE];
   logic [N_PRE-1:0] trace_nz;
   logic             stdp_upd;

   assign stdp_upd = bus.post_spike && (state == S_IDLE) && !bus.spike_valid;

   for (genvar g = 0; g < N_PRE; g++) begin : g_trace
      syn_trace #(.T_DW(T_DW)) u_trace (
         .clk    (clk),
         .rst    (rst),
         .accept (accept),
         .bit_in (bus.spike_vec[g]),
         .trace  (trace_q[g])
      );
      assign trace_nz[g] = |trace_q[g];
   end
`else
   logic unused_post;
   assign unused_post = bus.post_spike;
`endif

   // Register array so a learning step can rewrite every weight in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_PRE; i++) begin
            w_mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_PRE; i++) begin
            if (bus.w_we && (int'(bus.w_addr) == i)) begin
               w_mem[i] <= bus.w_data;
            end
`ifdef SYN_STDP_EN
            else if (stdp_upd) begin
               w_mem[i] <= W_DW'(sat_add(int'(w_mem[i]), trace_nz[i] ? LR : -LR, W_DW));
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_synapse_array.sv
// Directed bench for synapse_array (N_PRE=8, W_DW=16); learning scenario included when SYN_STDP_EN is defined.
module tb_synapse_array;
   localparam int N_PRE  = 8;
   localparam int W_DW   = 16;
   localparam int ACC_DW = 19;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   synapse_array_if #(.N_PRE(N_PRE), .W_DW(W_DW)) bus ();

   synapse_array #(.N_PRE(N_PRE), .W_DW(W_DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_w(input int a, input int d);
      bus.w_we   = 1'b1;
      bus.w_addr = 3'(a);
      bus.w_data = 16'(d);
      tick();
      bus.w_we   = 1'b0;
   endtask

   // lat = cycle index (accept cycle = 0) in which current_valid is seen.
   task automatic wait_result(input int start, output int lat);
      lat = start;
      while (bus.current_valid !== 1'b1 && lat < start + 40) begin
         tick();
         lat++;
      end
      checks++;
      if (bus.current_valid !== 1'b1) begin
         errors++;
         $display("FAIL result_timeout valid=%b want 1 within 40 cycles", bus.current_valid);
      end
   endtask

   task automatic run_vec(input logic [7:0] v, output int lat);
      bus.spike_vec   = v;
      bus.spike_valid = 1'b1;
      tick();
      bus.spike_valid = 1'b0;
      wait_result(1, lat);
   endtask

   task automatic test_reset();
      int lat;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (bus.spike_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b want 1", bus.spike_ready);
      end
      checks++;
      if (bus.current !== 19'sd0) begin
         errors++; $display("FAIL reset_current got %0d want 0", bus.current);
      end
      checks++;
      if (bus.current_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid got %b want 0", bus.current_valid);
      end
      run_vec(8'hFF, lat);
      checks++;
      if (bus.current !== 19'sd0) begin
         errors++; $display("FAIL reset_weights_sum got %0d want 0", bus.current);
      end
   endtask

   task automatic test_weighted_sum();
      int lat;
      for (int i = 0; i < N_PRE; i++) write_w(i, i + 1);
      run_vec(8'b1010_0101, lat);
      checks++;
      if (bus.current !== 19'sd18) begin
         errors++; $display("FAIL sum_a5 got %0d want 18", bus.current);
      end
      checks++;
      if (lat !== 10) begin
         errors++; $display("FAIL latency got %0d want 10", lat);
      end
      tick();
      checks++;
      if (bus.current_valid !== 1'b0) begin
         errors++; $display("FAIL valid_pulse_width got %b want 0", bus.current_valid);
      end
      tick();
      tick();
      checks++;
      if (bus.current !== 19'sd18) begin
         errors++; $display("FAIL current_hold got %0d want 18", bus.current);
      end
   endtask

   task automatic test_all_zero();
      int lat;
      run_vec(8'h00, lat);
      checks++;
      if (bus.current !== 19'sd0) begin
         errors++; $display("FAIL zero_vec got %0d want 0", bus.current);
      end
      checks++;
      if (lat !== 10) begin
         errors++; $display("FAIL zero_latency got %0d want 10", lat);
      end
   endtask

   task automatic test_min_weights();
      int lat;
      int e = -262144;
      for (int i = 0; i < N_PRE; i++) write_w(i, -32768);
      run_vec(8'hFF, lat);
      checks++;
      if (bus.current !== 19'(e)) begin
         errors++; $display("FAIL min_sum got %0d want %0d", bus.current, e);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      int lat;
      for (int i = 0; i < N_PRE; i++) write_w(i, i + 1);
      bus.spike_vec   = 8'h03;
      bus.spike_valid = 1'b1;
      tick();
      bus.spike_vec = 8'hF0;
      n = 0;
      while (bus.spike_ready !== 1'b1 && n < 30) begin
         n++;
         tick();
      end
      checks++;
      if (n !== N_PRE + 1) begin
         errors++; $display("FAIL b2b_ready_low got %0d want %0d", n, N_PRE + 1);
      end
      checks++;
      if (bus.current_valid !== 1'b1 || bus.current !== 19'sd3) begin
         errors++; $display("FAIL b2b_first got valid=%b cur=%0d want valid=1 cur=3",
                            bus.current_valid, bus.current);
      end
      tick();
      bus.spike_valid = 1'b0;
      wait_result(1, lat);
      checks++;
      if (bus.current !== 19'sd26) begin
         errors++; $display("FAIL b2b_second got %0d want 26", bus.current);
      end
      checks++;
      if (lat !== 10) begin
         errors++; $display("FAIL b2b_second_latency got %0d want 10", lat);
      end
   endtask

   task automatic test_write_collision();
      int lat;
      write_w(3, 5);
      bus.spike_vec   = 8'h09;
      bus.spike_valid = 1'b1;
      tick();
      bus.spike_valid = 1'b0;
      tick();
      tick();
      tick();
      // Cycle 4: idx == 3 is being summed now.
      bus.w_we   = 1'b1;
      bus.w_addr = 3'd3;
      bus.w_data = 16'sd100;
      tick();
      bus.w_we   = 1'b0;
      wait_result(5, lat);
      checks++;
      if (bus.current !== 19'sd6) begin
         errors++; $display("FAIL collision_old got %0d want 6", bus.current);
      end
      run_vec(8'h09, lat);
      checks++;
      if (bus.current !== 19'sd101) begin
         errors++; $display("FAIL collision_new got %0d want 101", bus.current);
      end
   endtask

   task automatic test_reset_mid_accum();
      int seen = 0;
      int lat;
      bus.spike_vec   = 8'hFF;
      bus.spike_valid = 1'b1;
      tick();
      bus.spike_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (bus.current_valid === 1'b1) seen++;
         tick();
      end
      checks++;
      if (seen !== 0) begin
         errors++; $display("FAIL midreset_pulse got %0d pulses want 0", seen);
      end
      checks++;
      if (bus.current !== 19'sd0) begin
         errors++; $display("FAIL midreset_current got %0d want 0", bus.current);
      end
      checks++;
      if (bus.spike_ready !== 1'b1) begin
         errors++; $display("FAIL midreset_ready got %b want 1", bus.spike_ready);
      end
      run_vec(8'hFF, lat);
      checks++;
      if (bus.current !== 19'sd0) begin
         errors++; $display("FAIL midreset_weights got %0d want 0", bus.current);
      end
   endtask

`ifdef SYN_STDP_EN
   task automatic test_stdp();
      int lat;
      int e;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      run_vec(8'h01, lat);
      bus.post_spike = 1'b1;
      tick();
      bus.post_spike = 1'b0;
      for (int i = 0; i < N_PRE; i++) begin
         run_vec(8'(1 << i), lat);
         e = (i == 0) ? 1 : -1;
         checks++;
         if (bus.current !== 19'(e)) begin
            errors++; $display("FAIL stdp_w%0d got %0d want %0d", i, bus.current, e);
         end
      end
      write_w(0, 32767);
      run_vec(8'h01, lat);
      bus.post_spike = 1'b1;
      tick();
      bus.post_spike = 1'b0;
      run_vec(8'h01, lat);
      checks++;
      if (bus.current !== 19'sd32767) begin
         errors++; $display("FAIL stdp_sat got %0d want 32767", bus.current);
      end
   endtask
`endif

   initial begin
      bus.spike_valid = 1'b0;
      bus.spike_vec   = '0;
      bus.w_we        = 1'b0;
      bus.w_addr      = '0;
      bus.w_data      = '0;
      bus.post_spike  = 1'b0;
      test_reset();
      test_weighted_sum();
      test_all_zero();
      test_min_weights();
      test_back_to_back();
      test_write_collision();
      test_reset_mid_accum();
`ifdef SYN_STDP_EN
      test_stdp();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1);
   end

endmodule
